// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Issues sequential imem reads with one request outstanding, buffers the
// returned words with their PC in a small FIFO, and hands them to decode
// over a valid/ready handshake. A redirect flushes the FIFO and discards
// any in-flight response.
module fetch_queue #(
    parameter int unsigned     xlen     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [xlen-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [xlen-1:0] imem_adr,
    input  logic [xlen-1:0] imem_resp,
    input  logic            imem_ack,
    input  logic            redirect_v,
    input  logic [xlen-1:0] redirect_pc,
    output logic            instr_v,
    output logic [xlen-1:0] instr,
    output logic [xlen-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t            state;
    logic [xlen-1:0]   fetch_pc;
    logic [xlen-1:0]   fifo_word [DEPTH];
    logic [xlen-1:0]   fifo_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [xlen-1:0]   last_instr;
    logic [xlen-1:0]   last_pc;
    logic [xlen-1:0]   redirect_tgt;
    logic              can_issue;
    logic              push;
    logic              pop;

    // Redirect target is word aligned; the low two bits are simply dropped.
    assign redirect_tgt = redirect_pc & ~xlen'(3);

    // Issuing only with a free slot guarantees the response always has room.
    assign can_issue = (count < CW'(DEPTH));

    // Only a clean ack in WAIT lands in the FIFO; redirect and KILL discard it.
    assign push    = (state == WAIT) && imem_ack && !redirect_v;
    assign instr_v = (count != '0);
    assign pop     = instr_v && instr_ready && !redirect_v;

    // Head entry when valid, otherwise the last head seen.
    assign instr    = instr_v ? fifo_word[rd_ptr] : last_instr;
    assign instr_pc = instr_v ? fifo_pc[rd_ptr]   : last_pc;

    // Fetch FSM: request issue, ack handling and redirect tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            imem_req <= 1'b0;
            imem_adr <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_v) begin
                        fetch_pc <= redirect_tgt;
                        imem_req <= 1'b0;
                    end else if (can_issue) begin
                        imem_req <= 1'b1;
                        imem_adr <= fetch_pc;
                        state    <= WAIT;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= FETCH;
                        fetch_pc <= redirect_v ? redirect_tgt : fetch_pc + xlen'(4);
                    end else if (redirect_v) begin
                        fetch_pc <= redirect_tgt;
                        state    <= KILL;
                    end
                end
                KILL: begin
                    // Request stays held with its old address; the reply is dropped.
                    if (redirect_v) fetch_pc <= redirect_tgt;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes and overrides any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_v) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: word plus the address it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= imem_resp;
            fifo_pc[wr_ptr]   <= imem_adr;
        end
    end

    // Remember the current head so the outputs hold once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_instr <= '0;
            last_pc    <= '0;
        end else if (instr_v) begin
            last_instr <= fifo_word[rd_ptr];
            last_pc    <= fifo_pc[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: sequential fetch, backpressure,
// redirect during a pending request, redirect racing ack and pop,
// PC wrap and asynchronous reset in the middle of a request.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_adr;
    logic [31:0] imem_resp;
    logic        imem_ack;
    logic        redirect_v;
    logic [31:0] redirect_pc;
    logic        instr_v;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.xlen(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_adr    (imem_adr),
        .imem_resp   (imem_resp),
        .imem_ack    (imem_ack),
        .redirect_v  (redirect_v),
        .redirect_pc (redirect_pc),
        .instr_v     (instr_v),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_resp   = '0;
        redirect_v  = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_resp   = '0;
        redirect_v  = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        #3;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
        checks++; if (imem_adr !== 32'h0) begin failures++; $display("FAIL reset_adr got=%0h exp=0", imem_adr); end
        checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL reset_instr_v got=%0h exp=0", instr_v); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%0h exp=0", instr_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] adrs [4];
        logic [31:0] words [3];
        logic [31:0] pcs [3];
        int na = 0;
        int np = 0;
        logic prev_ack = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (prev_ack) begin
                checks++; if (instr_v !== 1'b1) begin failures++; $display("FAIL seq_latency cyc=%0d instr_v got=%0h exp=1", i, instr_v); end
            end
            if (instr_v && np < 3) begin words[np] = instr; pcs[np] = instr_pc; np++; end
            imem_ack  = imem_req;
            imem_resp = imem_adr + 32'h100;
            if (imem_req && na < 4) begin adrs[na] = imem_adr; na++; end
            prev_ack = imem_req;
            step();
        end
        imem_ack = 1'b0;
        checks++; if (na != 4) begin failures++; $display("FAIL seq_req_count got=%0d exp=4", na); end
        checks++; if (np != 3) begin failures++; $display("FAIL seq_word_count got=%0d exp=3", np); end
        for (int i = 0; i < na; i++) begin
            checks++; if (adrs[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_adr%0d got=%0h exp=%0h", i, adrs[i], 4 * i); end
        end
        for (int i = 0; i < np; i++) begin
            checks++; if (words[i] !== 32'(4 * i + 32'h100)) begin failures++; $display("FAIL seq_instr%0d got=%0h exp=%0h", i, words[i], 4 * i + 32'h100); end
            checks++; if (pcs[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc%0d got=%0h exp=%0h", i, pcs[i], 4 * i); end
        end
    endtask

    task automatic test_backpressure();
        int nacks = 0;
        logic [31:0] adrs [8];
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = imem_req;
            imem_resp = imem_adr + 32'h100;
            if (imem_req) begin
                if (nacks < 8) adrs[nacks] = imem_adr;
                nacks++;
            end
            step();
        end
        imem_ack = 1'b0;
        checks++; if (nacks != 4) begin failures++; $display("FAIL full_fetch_count got=%0d exp=4", nacks); end
        for (int i = 0; i < 4 && i < nacks; i++) begin
            checks++; if (adrs[i] !== 32'(4 * i)) begin failures++; $display("FAIL full_adr%0d got=%0h exp=%0h", i, adrs[i], 4 * i); end
        end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req_idle got=%0h exp=0", imem_req); end
        checks++; if (instr_v !== 1'b1 || instr !== 32'h100 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL full_head got=%0h/%0h/%0h exp=1/100/0", instr_v, instr, instr_pc); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (instr_pc !== 32'h4 || instr !== 32'h104) begin failures++; $display("FAIL full_pop_head got=%0h/%0h exp=104/4", instr, instr_pc); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_pop_req got=%0h exp=0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h10) begin failures++; $display("FAIL full_refill got=%0h/%0h exp=1/10", imem_req, imem_adr); end
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0;
        logic got_adr = 1'b0;
        logic got_word = 1'b0;
        logic stale = 1'b0;
        logic [31:0] first_adr = '0;
        logic [31:0] first_pc = '0;
        logic [31:0] first_word = '0;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'b0;
            if (imem_req && imem_adr == 32'h8) begin found = 1'b1; break; end
            imem_ack  = imem_req;
            imem_resp = imem_adr + 32'h100;
            step();
        end
        checks++; if (!found) begin failures++; $display("FAIL rw_reach_adr8 got=0 exp=1"); end
        imem_ack = 1'b0;
        step();
        redirect_v  = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect_v = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h8) begin failures++; $display("FAIL rw_hold1 got=%0h/%0h exp=1/8", imem_req, imem_adr); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h8) begin failures++; $display("FAIL rw_hold2 got=%0h/%0h exp=1/8", imem_req, imem_adr); end
        imem_ack  = 1'b1;
        imem_resp = 32'hDEAD;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_v) begin
                if (instr_pc == 32'h8 || instr == 32'hDEAD) stale = 1'b1;
                if (!got_word) begin got_word = 1'b1; first_pc = instr_pc; first_word = instr; end
            end
            if (imem_req && !got_adr) begin got_adr = 1'b1; first_adr = imem_adr; end
            imem_ack  = imem_req;
            imem_resp = imem_adr + 32'h100;
            step();
        end
        imem_ack = 1'b0;
        checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rw_stale got=1 exp=0"); end
        checks++; if (first_adr !== 32'h200) begin failures++; $display("FAIL rw_next_adr got=%0h exp=200", first_adr); end
        checks++; if (first_pc !== 32'h200 || first_word !== 32'h300) begin failures++; $display("FAIL rw_first_word got=%0h/%0h exp=300/200", first_word, first_pc); end
    endtask

    task automatic test_redirect_ack_pop();
        int nacks = 0;
        logic found = 1'b0;
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'b0;
            if (imem_req && nacks >= 2) begin found = 1'b1; break; end
            imem_ack  = imem_req;
            imem_resp = imem_adr + 32'h100;
            if (imem_req) nacks++;
            step();
        end
        checks++; if (!found || imem_adr !== 32'h8) begin failures++; $display("FAIL rap_setup got=%0h/%0h exp=1/8", found, imem_adr); end
        checks++; if (instr_v !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL rap_head got=%0h/%0h exp=1/0", instr_v, instr_pc); end
        instr_ready = 1'b1;
        redirect_v  = 1'b1;
        redirect_pc = 32'h400;
        imem_ack    = 1'b1;
        imem_resp   = 32'hBAD;
        step();
        redirect_v = 1'b0;
        imem_ack   = 1'b0;
        checks++; if (instr_v !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rap_flush got=%0h/%0h exp=0/0", instr_v, imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h400) begin failures++; $display("FAIL rap_next_adr got=%0h/%0h exp=1/400", imem_req, imem_adr); end
        checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL rap_still_empty got=%0h exp=0", instr_v); end
        imem_ack  = 1'b1;
        imem_resp = 32'h500;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_v !== 1'b1 || instr_pc !== 32'h400 || instr !== 32'h500) begin
            failures++; $display("FAIL rap_first_word got=%0h/%0h/%0h exp=1/500/400", instr_v, instr, instr_pc); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        instr_ready = 1'b1;
        redirect_v  = 1'b1;
        redirect_pc = 32'hFFFFFFFE;
        step();
        redirect_v = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_no_issue got=%0h exp=0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_adr0 got=%0h/%0h exp=1/fffffffc", imem_req, imem_adr); end
        imem_ack  = 1'b1;
        imem_resp = 32'h77;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_v !== 1'b1 || instr_pc !== 32'hFFFFFFFC || instr !== 32'h77) begin
            failures++; $display("FAIL wrap_word got=%0h/%0h/%0h exp=1/77/fffffffc", instr_v, instr, instr_pc); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h0) begin failures++; $display("FAIL wrap_adr1 got=%0h/%0h exp=1/0", imem_req, imem_adr); end
        imem_ack  = 1'b1;
        imem_resp = 32'h88;
        step();
        imem_ack = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h4) begin failures++; $display("FAIL rst_prewait got=%0h/%0h exp=1/4", imem_req, imem_adr); end
        // Drop reset between clock edges while the request to 4 is pending.
        instr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_adr !== 32'h0) begin failures++; $display("FAIL rst_async_req got=%0h/%0h exp=0/0", imem_req, imem_adr); end
        checks++; if (instr_v !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL rst_async_out got=%0h/%0h/%0h exp=0/0/0", instr_v, instr, instr_pc); end
        imem_ack  = 1'b1;
        imem_resp = 32'h99;
        step();
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL rst_late_ack got=%0h exp=0", instr_v); end
        checks++; if (imem_req !== 1'b1 || imem_adr !== 32'h0) begin failures++; $display("FAIL rst_restart got=%0h/%0h exp=1/0", imem_req, imem_adr); end
        imem_ack  = 1'b1;
        imem_resp = 32'h100;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_v !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h100) begin
            failures++; $display("FAIL rst_first_word got=%0h/%0h/%0h exp=1/100/0", instr_v, instr, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
